// File: rtl/arbitro_mux_pkg.sv
// Shared definitions for the arbitro_mux round-robin scheduler.
//   DATA_W  : default word width of the channel FIFOs and the output path
//   ACTIVE  : main-FSM state code in which arbitration is allowed
//   arb_state_e : scheduler FSM states (IDLE / ARB / DRAIN)
//   onehot_idx  : converts a one-hot (or zero) 4-bit vector to a 2-bit index
package arbitro_mux_pkg;

    localparam int unsigned DATA_W = 10;
    localparam logic [3:0]  ACTIVE = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbitro_mux_rr_pick4.sv
// rr_pick4: combinational rotating-priority picker for four requesters.
//   elig   [3:0] : per-queue eligibility
//   rr_ptr [1:0] : index searched first; search proceeds rr_ptr, rr_ptr+1, ... mod 4
//   gnt    [3:0] : one-hot grant of the first eligible index (zero if none)
//   found        : at least one index is eligible
module rr_pick4 (
    input  logic [3:0] elig,
    input  logic [1:0] rr_ptr,
    output logic [3:0] gnt,
    output logic       found
);

    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < 4; off++) begin
            // 2-bit addition wraps naturally, giving the mod-4 rotation
            idx = rr_ptr + off[1:0];
            if (!found && elig[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_mux.sv
// arbitro_mux: round-robin scheduler merging four virtual-channel FIFOs
// (P0..P3) into one downstream FIFO, one word per cycle at most.
//   clk, reset_L  : clock, synchronous active-low reset
//   state         : main FSM state; arbitration only while state == ACTIVE
//   empty [3:0]   : per-FIFO empty flags (bit i belongs to Pi)
//   P0..P3        : FIFO read data, valid the cycle after that FIFO's pop
//   almost_full   : downstream backpressure (leaves >= 2 free slots)
//   pop [3:0]     : registered one-hot-or-zero pop strobes
//   push          : registered downstream write strobe
//   data_out      : registered word written when push = 1
//   grant [1:0]   : index of the most recent pop
//   idle          : IDLE with nothing in flight
//   words_out     : wrapping count of pushes
module arbitro_mux #(
    parameter int unsigned DATA_W = arbitro_mux_pkg::DATA_W,
    parameter logic [3:0]  ACTIVE = arbitro_mux_pkg::ACTIVE
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [3:0]        state,
    input  logic [3:0]        empty,
    input  logic [DATA_W-1:0] P0,
    input  logic [DATA_W-1:0] P1,
    input  logic [DATA_W-1:0] P2,
    input  logic [DATA_W-1:0] P3,
    input  logic              almost_full,
    output logic [3:0]        pop,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        grant,
    output logic              idle,
    output logic [7:0]        words_out
);

    import arbitro_mux_pkg::*;

    arb_state_e        fsm_q, fsm_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]        pop_q, pop_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [1:0]        grant_q, grant_d;
    logic [7:0]        words_out_q, words_out_d;
    logic              cap_vld_q, cap_vld_d;
    logic [1:0]        cap_idx_q, cap_idx_d;

    logic              is_active;
    logic              can_pop;
    logic              idle_c;
    logic [3:0]        elig;
    logic [3:0]        pick_gnt;
    logic              pick_found;
    logic [1:0]        pick_idx;
    logic [DATA_W-1:0] sel_word;

    assign is_active = (state == ACTIVE);

    // The empty flag of a queue popped this cycle has not yet updated, so
    // that queue is skipped for the next decision.
    assign elig = ~empty & ~pop_q;

    rr_pick4 u_pick (
        .elig   (elig),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .found  (pick_found)
    );

    assign pick_idx = onehot_idx(pick_gnt);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (is_active) fsm_d = ARB;
            end
            ARB: begin
                if (!is_active) fsm_d = DRAIN;
            end
            DRAIN: begin
                if (is_active) begin
                    fsm_d = ARB;
                end else if (pop_q == '0 && !cap_vld_q) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // FSM outputs: pop permission and idle indication.
    // Requiring is_active here means a state drop (or a simultaneous
    // almost_full/state change) blocks the pop registered at the same edge.
    always_comb begin
        can_pop = (fsm_q == ARB) && is_active && !almost_full && pick_found;
        idle_c  = (fsm_q == IDLE) && (pop_q == '0) && !cap_vld_q && !push_q;
    end

    always_comb begin
        case (cap_idx_q)
            2'd0:    sel_word = P0;
            2'd1:    sel_word = P1;
            2'd2:    sel_word = P2;
            default: sel_word = P3;
        endcase
    end

    // Pop -> capture -> push pipeline and counters
    always_comb begin
        pop_d       = can_pop ? pick_gnt : '0;
        rr_ptr_d    = can_pop ? (pick_idx + 2'd1) : rr_ptr_q;
        grant_d     = can_pop ? pick_idx : grant_q;
        // grant_q names the queue whose pop is currently on pop_q
        cap_vld_d   = (pop_q != '0);
        cap_idx_d   = (pop_q != '0) ? grant_q : cap_idx_q;
        push_d      = cap_vld_q;
        data_out_d  = cap_vld_q ? sel_word : data_out_q;
        words_out_d = words_out_q + {7'd0, cap_vld_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rr_ptr_q    <= '0;
            pop_q       <= '0;
            push_q      <= 1'b0;
            data_out_q  <= '0;
            grant_q     <= '0;
            words_out_q <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pop_q       <= pop_d;
            push_q      <= push_d;
            data_out_q  <= data_out_d;
            grant_q     <= grant_d;
            words_out_q <= words_out_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    assign pop       = pop_q;
    assign push      = push_q;
    assign data_out  = data_out_q;
    assign grant     = grant_q;
    assign idle      = idle_c;
    assign words_out = words_out_q;

endmodule

// File: tb/tb_arbitro_mux.sv
// Testbench for arbitro_mux: behavioural models of the four channel FIFOs,
// directed stimulus, and a scoreboard of expected pops and pushed words.
module tb_arbitro_mux;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] state;
    logic [3:0] empty;
    logic [9:0] p_data [4];
    logic       almost_full;
    logic [3:0] pop;
    logic       push;
    logic [9:0] data_out;
    logic [1:0] grant;
    logic       idle;
    logic [7:0] words_out;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_pop_q  [$];
    logic [9:0] exp_data_q [$];

    // Channel FIFO models: written from the stimulus, read on DUT pops.
    logic [9:0]  mem [4][64];
    int unsigned wr_ptr [4];
    int unsigned rd_ptr [4];
    logic        flush;

    always #5 clk = ~clk;

    arbitro_mux #(.DATA_W(10), .ACTIVE(4'b1000)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .state       (state),
        .empty       (empty),
        .P0          (p_data[0]),
        .P1          (p_data[1]),
        .P2          (p_data[2]),
        .P3          (p_data[3]),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .grant       (grant),
        .idle        (idle),
        .words_out   (words_out)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flush) begin
                rd_ptr[i] <= wr_ptr[i];
            end else if (pop[i]) begin
                p_data[i] <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (rd_ptr[i] == wr_ptr[i]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic load(input int q, input logic [9:0] w);
        mem[q][wr_ptr[q]] = w;
        wr_ptr[q]++;
    endtask

    task automatic exp_pop(input logic [3:0] oh);
        exp_pop_q.push_back(oh);
    endtask

    task automatic exp_word(input logic [9:0] w);
        exp_data_q.push_back(w);
    endtask

    // Reset DUT and flush FIFO models; leaves state inactive.
    task automatic do_reset();
        state       = 4'b0000;
        almost_full = 1'b0;
        reset_L     = 1'b0;
        flush       = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        @(negedge clk);
        reset_L     = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_first_pop(input string name);
        int n;
        n = 0;
        while (pop == 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (pop == 4'b0000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_pop required=pop", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_pop_q.size() != 0 || exp_data_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drained"}, exp_pop_q.size() + exp_data_q.size(), 0);
    endtask

    // Scoreboard monitor: every observed pop/push is matched in order.
    always @(negedge clk) begin
        if (pop != 4'b0000) begin
            if (exp_pop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none", pop);
            end else begin
                chk("pop_order", pop, exp_pop_q.pop_front());
            end
        end
        if (push) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL push_unexpected actual=%0h required=none", data_out);
            end else begin
                chk("data_out", data_out, exp_data_q.pop_front());
            end
        end
    end

    initial begin
        reset_L     = 1'b0;
        state       = 4'b1000;
        almost_full = 1'b0;
        flush       = 1'b0;
        for (int i = 0; i < 4; i++) wr_ptr[i] = 0;

        // 1: reset held two cycles with every queue non-empty
        load(0, 10'h0AA); load(1, 10'h0BB); load(2, 10'h0CC); load(3, 10'h0DD);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pop", pop, 4'b0000);
        chk("rst_push", push, 1'b0);
        chk("rst_data", data_out, 10'h000);
        chk("rst_grant", grant, 2'd0);
        chk("rst_words", words_out, 8'd0);
        chk("rst_idle", idle, 1'b1);
        do_reset();
        chk("post_rst_idle", idle, 1'b1);

        // 2: all four queues loaded, back-to-back round robin
        load(0, 10'h011); load(1, 10'h022); load(2, 10'h033); load(3, 10'h044);
        load(0, 10'h111); load(1, 10'h122); load(2, 10'h133); load(3, 10'h144);
        for (int r = 0; r < 2; r++) begin
            exp_pop(4'b0001); exp_pop(4'b0010); exp_pop(4'b0100); exp_pop(4'b1000);
        end
        exp_word(10'h011); exp_word(10'h022); exp_word(10'h033); exp_word(10'h044);
        exp_word(10'h111); exp_word(10'h122); exp_word(10'h133); exp_word(10'h144);
        state = 4'b1000;
        wait_first_pop("t2");
        for (int j = 0; j < 10; j++) begin
            if (j < 8)  chk("t2_pop_busy", (pop != 4'b0000), 1'b1);
            if (j >= 2) chk("t2_push_busy", push, 1'b1);
            @(negedge clk);
        end
        wait_drain("t2");
        chk("t2_words", words_out, 8'd8);
        chk("t2_grant", grant, 2'd3);

        // 3: single non-empty queue pops every other cycle
        do_reset();
        load(2, 10'h2A1); load(2, 10'h2A2); load(2, 10'h2A3);
        exp_pop(4'b0100); exp_pop(4'b0100); exp_pop(4'b0100);
        exp_word(10'h2A1); exp_word(10'h2A2); exp_word(10'h2A3);
        state = 4'b1000;
        wait_first_pop("t3");
        for (int j = 0; j < 6; j++) begin
            chk("t3_alt", pop, (j % 2 == 0 && j < 6) ? 4'b0100 : 4'b0000);
            @(negedge clk);
        end
        wait_drain("t3");
        chk("t3_words", words_out, 8'd3);
        chk("t3_grant", grant, 2'd2);

        // 4: almost_full one cycle after pops start
        do_reset();
        load(0, 10'h301); load(1, 10'h302); load(2, 10'h303); load(3, 10'h304);
        load(0, 10'h305); load(1, 10'h306); load(2, 10'h307); load(3, 10'h308);
        for (int r = 0; r < 2; r++) begin
            exp_pop(4'b0001); exp_pop(4'b0010); exp_pop(4'b0100); exp_pop(4'b1000);
        end
        exp_word(10'h301); exp_word(10'h302); exp_word(10'h303); exp_word(10'h304);
        exp_word(10'h305); exp_word(10'h306); exp_word(10'h307); exp_word(10'h308);
        state = 4'b1000;
        wait_first_pop("t4");
        @(negedge clk);
        almost_full = 1'b1;
        @(negedge clk);
        chk("t4_push1", push, 1'b1);
        @(negedge clk);
        chk("t4_push2", push, 1'b1);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("t4_hold_push", push, 1'b0);
            chk("t4_hold_pop", pop, 4'b0000);
        end
        almost_full = 1'b0;
        wait_drain("t4");
        chk("t4_words", words_out, 8'd8);

        // 5: state leaves ACTIVE mid-stream
        do_reset();
        load(0, 10'h501); load(1, 10'h502); load(2, 10'h503); load(3, 10'h504);
        exp_pop(4'b0001); exp_pop(4'b0010);
        exp_word(10'h501); exp_word(10'h502);
        state = 4'b1000;
        wait_first_pop("t5");
        @(negedge clk);
        state = 4'b0010;
        @(negedge clk);
        chk("t5_push_a", push, 1'b1);
        chk("t5_busy_a", idle, 1'b0);
        chk("t5_nopop", pop, 4'b0000);
        @(negedge clk);
        chk("t5_push_b", push, 1'b1);
        chk("t5_busy_b", idle, 1'b0);
        @(negedge clk);
        chk("t5_push_end", push, 1'b0);
        chk("t5_idle", idle, 1'b1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t5_quiet", pop, 4'b0000);
        end
        chk("t5_words", words_out, 8'd2);

        // 6: reset with two words in flight
        do_reset();
        load(0, 10'h601); load(1, 10'h602); load(2, 10'h603); load(3, 10'h604);
        exp_pop(4'b0001); exp_pop(4'b0010);
        state = 4'b1000;
        wait_first_pop("t6");
        @(negedge clk);
        state   = 4'b0000;
        reset_L = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("t6_nopush", push, 1'b0);
            chk("t6_words", words_out, 8'd0);
            @(negedge clk);
        end
        reset_L = 1'b1;
        @(negedge clk);
        chk("t6_idle", idle, 1'b1);
        load(0, 10'h611); load(1, 10'h612); load(2, 10'h613); load(3, 10'h614);
        exp_pop(4'b0001); exp_pop(4'b0010); exp_pop(4'b0100); exp_pop(4'b1000);
        exp_word(10'h611); exp_word(10'h612); exp_word(10'h613); exp_word(10'h614);
        state = 4'b1000;
        wait_first_pop("t6b");
        chk("t6_ptr_restart", pop, 4'b0001);
        wait_drain("t6");
        chk("t6_words_after", words_out, 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
